ysyx_24090012_trap_ctrl: RTL and testbench

//  Sequences the machine-mode trap and return flow onto the single CSR write port. Handles ECALL, synchronous exceptions,

---
 rtl/ysyx_24090012_trap_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ysyx_24090012_trap_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24090012_trap_ctrl.sv
// Machine-mode trap/return sequencer.
// Takes one request from WBU (ECALL, MRET, exception) or a pending timer
// interrupt, writes MEPC/MCAUSE/MSTATUS in order over a single CSR write
// port, then pulses a one-cycle PC redirect to IFU.
//
// Handshakes: a transfer happens on a cycle where valid && ready are both
// high at the rising clock edge. The producer holds valid and its payload
// stable until that edge. Here the trap port has WBU as producer and this
// block as consumer. The CSR write port has this block as producer and the
// CSR file as consumer.
module ysyx_24090012_trap_ctrl #(
  parameter logic [31:0] ECALL_CAUSE = 32'h0000000b,
  parameter logic [31:0] IRQ_CAUSE   = 32'h80000007,
  parameter logic [1:0]  MPP_M       = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_valid,
  output logic        trap_ready,
  input  logic [1:0]  trap_kind,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        irq_timer,
  input  logic [31:0] irq_pc,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  input  logic [31:0] mstatus_in,
  output logic        csr_wr_valid,
  input  logic        csr_wr_ready,
  output logic [11:0] csr_wr_addr,
  output logic [31:0] csr_wr_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_EPC    = 3'd1,
    S_W_CAUSE  = 3'd2,
    S_W_STATUS = 3'd3,
    S_REDIR    = 3'd4
  } state_e;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  localparam logic [1:0] KIND_ECALL = 2'b00;
  localparam logic [1:0] KIND_MRET  = 2'b01;
  localparam logic [1:0] KIND_EXC   = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic        mret_q, mret_d;

  logic [31:0] status_trap;
  logic [31:0] status_mret;

  // State register and snapshot registers; reset drops any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
      mstatus_q <= '0;
      mepc_q    <= '0;
      mtvec_q   <= '0;
      mret_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      mstatus_q <= mstatus_d;
      mepc_q    <= mepc_d;
      mtvec_q   <= mtvec_d;
      mret_q    <= mret_d;
    end
  end

  // Next-state: accept a request in IDLE, advance write states on handshake.
  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    mstatus_d = mstatus_q;
    mepc_d    = mepc_q;
    mtvec_d   = mtvec_q;
    mret_d    = mret_q;
    case (state_q)
      S_IDLE: begin
        if (trap_valid) begin
          // A WBU request always wins over the interrupt in the same cycle.
          if (trap_kind == KIND_ECALL || trap_kind == KIND_EXC) begin
            epc_d     = trap_pc;
            cause_d   = (trap_kind == KIND_ECALL) ? ECALL_CAUSE : trap_cause;
            mret_d    = 1'b0;
            mstatus_d = mstatus_in;
            mepc_d    = mepc_in;
            mtvec_d   = mtvec_in;
            state_d   = S_W_EPC;
          end else if (trap_kind == KIND_MRET) begin
            mret_d    = 1'b1;
            mstatus_d = mstatus_in;
            mepc_d    = mepc_in;
            mtvec_d   = mtvec_in;
            state_d   = S_W_STATUS;
          end
          // Reserved kind: handshake completes, nothing else happens.
        end else if (irq_timer && mstatus_in[3]) begin
          epc_d     = irq_pc;
          cause_d   = IRQ_CAUSE;
          mret_d    = 1'b0;
          mstatus_d = mstatus_in;
          mepc_d    = mepc_in;
          mtvec_d   = mtvec_in;
          state_d   = S_W_EPC;
        end
      end
      S_W_EPC:    if (csr_wr_ready) state_d = S_W_CAUSE;
      S_W_CAUSE:  if (csr_wr_ready) state_d = S_W_STATUS;
      S_W_STATUS: if (csr_wr_ready) state_d = S_REDIR;
      S_REDIR:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs: depend only on state and snapshots, so they are stable while stalled.
  always_comb begin
    status_trap        = mstatus_q;
    status_trap[7]     = mstatus_q[3];
    status_trap[3]     = 1'b0;
    status_trap[12:11] = MPP_M;

    status_mret        = mstatus_q;
    status_mret[3]     = mstatus_q[7];
    status_mret[7]     = 1'b1;
    status_mret[12:11] = MPP_M;

    trap_ready     = (state_q == S_IDLE);
    busy           = (state_q != S_IDLE);
    csr_wr_valid   = 1'b0;
    csr_wr_addr    = '0;
    csr_wr_data    = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      S_W_EPC: begin
        csr_wr_valid = 1'b1;
        csr_wr_addr  = ADDR_MEPC;
        csr_wr_data  = epc_q;
      end
      S_W_CAUSE: begin
        csr_wr_valid = 1'b1;
        csr_wr_addr  = ADDR_MCAUSE;
        csr_wr_data  = cause_q;
      end
      S_W_STATUS: begin
        csr_wr_valid = 1'b1;
        csr_wr_addr  = ADDR_MSTATUS;
        csr_wr_data  = mret_q ? status_mret : status_trap;
      end
      S_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = mret_q ? mepc_q : {mtvec_q[31:2], 2'b00};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24090012_trap_ctrl.sv
// Bench for the trap/return sequencer: reset, directed vectors, multi-cycle
// corner cases, and randomized traffic against a queue-based action model.
module tb_ysyx_24090012_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        trap_valid;
  logic        trap_ready;
  logic [1:0]  trap_kind;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        irq_timer;
  logic [31:0] irq_pc;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic [31:0] mstatus_in;
  logic        csr_wr_valid;
  logic        csr_wr_ready;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ysyx_24090012_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .trap_valid(trap_valid), .trap_ready(trap_ready), .trap_kind(trap_kind),
    .trap_cause(trap_cause), .trap_pc(trap_pc),
    .irq_timer(irq_timer), .irq_pc(irq_pc),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in), .mstatus_in(mstatus_in),
    .csr_wr_valid(csr_wr_valid), .csr_wr_ready(csr_wr_ready),
    .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_idle(input string n);
    chk({n, ".wr_valid"}, 32'(csr_wr_valid), 32'd0);
    chk({n, ".redir"}, 32'(redirect_valid), 32'd0);
    chk({n, ".busy"}, 32'(busy), 32'd0);
    chk({n, ".trap_ready"}, 32'(trap_ready), 32'd1);
  endtask

  task automatic expect_wr(input string n, input logic [11:0] a, input logic [31:0] d);
    chk({n, ".wr_valid"}, 32'(csr_wr_valid), 32'd1);
    chk({n, ".wr_addr"}, 32'(csr_wr_addr), 32'(a));
    chk({n, ".wr_data"}, csr_wr_data, d);
    chk({n, ".redir"}, 32'(redirect_valid), 32'd0);
    chk({n, ".busy"}, 32'(busy), 32'd1);
    chk({n, ".trap_ready"}, 32'(trap_ready), 32'd0);
  endtask

  task automatic expect_redir(input string n, input logic [31:0] pc);
    chk({n, ".wr_valid"}, 32'(csr_wr_valid), 32'd0);
    chk({n, ".redir"}, 32'(redirect_valid), 32'd1);
    chk({n, ".redir_pc"}, redirect_pc, pc);
    chk({n, ".busy"}, 32'(busy), 32'd1);
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive_idle_inputs();
    trap_valid   = 1'b0;
    trap_kind    = 2'b00;
    trap_cause   = '0;
    trap_pc      = '0;
    irq_timer    = 1'b0;
    irq_pc       = '0;
    mtvec_in     = '0;
    mepc_in      = '0;
    mstatus_in   = '0;
    csr_wr_ready = 1'b1;
  endtask

  task automatic scramble_csrs();
    mtvec_in   = $urandom;
    mepc_in    = $urandom;
    mstatus_in = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Expected mstatus after trap entry and after MRET, from the field rules.
  function automatic logic [31:0] model_trap_status(input logic [31:0] s);
    return (s & ~32'h0000_1888) | (((s >> 3) & 32'h1) << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] model_mret_status(input logic [31:0] s);
    return (s & ~32'h0000_1888) | (((s >> 7) & 32'h1) << 3) | 32'h0000_1880;
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    string       name;
    logic [1:0]  kind;
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mstatus;
    logic [31:0] exp_cause;
    logic [31:0] exp_status;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    trap_valid = 1'b1;
    trap_kind  = v.kind;
    trap_pc    = v.pc;
    trap_cause = v.cause;
    mtvec_in   = v.mtvec;
    mepc_in    = v.mepc;
    mstatus_in = v.mstatus;
    expect_idle({v.name, ".c0"});
    @(negedge clk);
    trap_valid = 1'b0;
    irq_timer  = 1'b0;
    scramble_csrs();
    if (v.kind == 2'b00 || v.kind == 2'b10) begin
      expect_wr({v.name, ".c1"}, 12'h341, v.pc);
      @(negedge clk);
      expect_wr({v.name, ".c2"}, 12'h342, v.exp_cause);
      @(negedge clk);
      expect_wr({v.name, ".c3"}, 12'h300, v.exp_status);
      @(negedge clk);
      expect_redir({v.name, ".c4"}, v.exp_pc);
      @(negedge clk);
      expect_idle({v.name, ".c5"});
    end else if (v.kind == 2'b01) begin
      expect_wr({v.name, ".c1"}, 12'h300, v.exp_status);
      @(negedge clk);
      expect_redir({v.name, ".c2"}, v.exp_pc);
      @(negedge clk);
      expect_idle({v.name, ".c3"});
    end else begin
      expect_idle({v.name, ".c1"});
      @(negedge clk);
      expect_idle({v.name, ".c2"});
    end
  endtask

  // ---------------- random model state ----------------
  // Each pending action: {is_redirect, addr[11:0], data[31:0]}.
  logic [44:0] exp_q[$];

  task automatic model_push_trap(input logic [31:0] epc, input logic [31:0] cause,
                                 input logic [31:0] ms, input logic [31:0] tv);
    exp_q.push_back({1'b0, 12'h341, epc});
    exp_q.push_back({1'b0, 12'h342, cause});
    exp_q.push_back({1'b0, 12'h300, model_trap_status(ms)});
    exp_q.push_back({1'b1, 12'h000, tv & 32'hFFFF_FFFC});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [44:0] fr;
    logic        req_pending;
    rst = 1'b1;
    drive_idle_inputs();

    // Reset values while reset is held.
    @(negedge clk);
    chk("rst.wr_valid", 32'(csr_wr_valid), 32'd0);
    chk("rst.wr_addr", 32'(csr_wr_addr), 32'd0);
    chk("rst.wr_data", csr_wr_data, 32'd0);
    chk("rst.redir", 32'(redirect_valid), 32'd0);
    chk("rst.redir_pc", redirect_pc, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.trap_ready", 32'(trap_ready), 32'd1);
    do_reset();

    // Table: name kind pc cause mtvec mepc mstatus exp_cause exp_status exp_pc
    vecs[0] = '{"ecall", 2'b00, 32'h80000100, 32'h0, 32'h80001003, 32'h0, 32'h8,
                32'hb, 32'h1880, 32'h80001000};
    vecs[1] = '{"mret", 2'b01, 32'h0, 32'h0, 32'h0, 32'h80000104, 32'h80,
                32'h0, 32'h1888, 32'h80000104};
    vecs[2] = '{"exc", 2'b10, 32'h80000300, 32'h2, 32'h80002000, 32'h0, 32'h0,
                32'h2, 32'h1800, 32'h80002000};
    vecs[3] = '{"ecall_ones", 2'b00, 32'h80000ABC, 32'h5, 32'h80000FFF, 32'h0, 32'hFFFFFFFF,
                32'hb, 32'hFFFFFFF7, 32'h80000FFC};
    vecs[4] = '{"mret_mie", 2'b01, 32'h0, 32'h0, 32'h0, 32'h80000400, 32'h8,
                32'h0, 32'h1880, 32'h80000400};
    vecs[5] = '{"mret_ones", 2'b01, 32'h0, 32'h0, 32'h0, 32'h80000500, 32'hFFFFE7FF,
                32'h0, 32'hFFFFFFFF, 32'h80000500};
    vecs[6] = '{"reserved", 2'b11, 32'h80000600, 32'h9, 32'h80003000, 32'h0, 32'h8,
                32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Stall in the mcause write for three cycles.
    @(negedge clk);
    trap_valid = 1'b1; trap_kind = 2'b00; trap_pc = 32'h80000700;
    mtvec_in = 32'h80004000; mstatus_in = 32'h8;
    @(negedge clk);
    trap_valid = 1'b0;
    expect_wr("stall.c1", 12'h341, 32'h80000700);
    @(negedge clk);
    expect_wr("stall.c2", 12'h342, 32'hb);
    csr_wr_ready = 1'b0;
    for (int i = 3; i <= 4; i++) begin
      @(negedge clk);
      expect_wr($sformatf("stall.c%0d", i), 12'h342, 32'hb);
    end
    @(negedge clk);
    expect_wr("stall.c5", 12'h342, 32'hb);
    csr_wr_ready = 1'b1;
    @(negedge clk);
    expect_wr("stall.c6", 12'h300, 32'h1880);
    @(negedge clk);
    expect_redir("stall.c7", 32'h80004000);
    @(negedge clk);
    expect_idle("stall.c8");

    // Exception and interrupt in the same cycle: exception first, irq after.
    trap_valid = 1'b1; trap_kind = 2'b10; trap_cause = 32'h2; trap_pc = 32'h80000800;
    irq_timer = 1'b1; irq_pc = 32'h80000900; mtvec_in = 32'h80005000; mstatus_in = 32'h8;
    @(negedge clk);
    trap_valid = 1'b0;
    expect_wr("prio.c1", 12'h341, 32'h80000800);
    @(negedge clk);
    expect_wr("prio.c2", 12'h342, 32'h2);
    @(negedge clk);
    expect_wr("prio.c3", 12'h300, 32'h1880);
    @(negedge clk);
    expect_redir("prio.c4", 32'h80005000);
    @(negedge clk);
    expect_idle("prio.c5");
    @(negedge clk);
    expect_wr("prio.c6", 12'h341, 32'h80000900);
    irq_timer = 1'b0;
    @(negedge clk);
    expect_wr("prio.c7", 12'h342, 32'h80000007);
    @(negedge clk);
    expect_wr("prio.c8", 12'h300, 32'h1880);
    @(negedge clk);
    expect_redir("prio.c9", 32'h80005000);
    @(negedge clk);
    expect_idle("prio.c10");

    // Interrupt gated by MIE, then taken; irq drops mid-sequence.
    irq_timer = 1'b1; mstatus_in = 32'h0; irq_pc = 32'h80000200; mtvec_in = 32'h80006001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_idle($sformatf("gate.c%0d", i));
    end
    mstatus_in = 32'h8;
    @(negedge clk);
    expect_wr("irq.c1", 12'h341, 32'h80000200);
    irq_timer = 1'b0;
    scramble_csrs();
    @(negedge clk);
    expect_wr("irq.c2", 12'h342, 32'h80000007);
    @(negedge clk);
    expect_wr("irq.c3", 12'h300, 32'h1880);
    @(negedge clk);
    expect_redir("irq.c4", 32'h80006000);
    mstatus_in = 32'h0;
    @(negedge clk);
    expect_idle("irq.c5");

    // Reset asserted during the mcause write.
    trap_valid = 1'b1; trap_kind = 2'b00; trap_pc = 32'h80000A00;
    mtvec_in = 32'h80007000; mstatus_in = 32'h0;
    @(negedge clk);
    trap_valid = 1'b0;
    expect_wr("rmid.c1", 12'h341, 32'h80000A00);
    @(negedge clk);
    expect_wr("rmid.c2", 12'h342, 32'hb);
    rst = 1'b1;
    @(negedge clk);
    expect_idle("rmid.c3");
    chk("rmid.wr_addr", 32'(csr_wr_addr), 32'd0);
    rst = 1'b0;
    for (int i = 4; i < 8; i++) begin
      @(negedge clk);
      expect_idle($sformatf("rmid.c%0d", i));
    end

    // Randomized traffic against the action-queue model.
    do_reset();
    exp_q.delete();
    req_pending = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      // Compare the current cycle against the model.
      if (exp_q.size() == 0) begin
        expect_idle("rnd.idle");
      end else begin
        fr = exp_q[0];
        if (fr[44]) expect_redir("rnd.redir", fr[31:0]);
        else expect_wr("rnd.wr", fr[43:32], fr[31:0]);
      end
      // New stimulus; a pending WBU request is held until accepted.
      if (!req_pending && $urandom_range(0, 3) == 0) begin
        req_pending = 1'b1;
        trap_kind   = 2'($urandom_range(0, 3));
        trap_cause  = $urandom;
        trap_pc     = $urandom;
      end
      trap_valid   = req_pending;
      irq_timer    = ($urandom_range(0, 2) == 0);
      irq_pc       = $urandom;
      scramble_csrs();
      csr_wr_ready = ($urandom_range(0, 3) != 0);
      // Model what happens at the coming rising edge.
      if (exp_q.size() != 0) begin
        fr = exp_q[0];
        if (fr[44] || csr_wr_ready) void'(exp_q.pop_front());
      end else if (trap_valid) begin
        req_pending = 1'b0;
        case (trap_kind)
          2'b00: model_push_trap(trap_pc, 32'hb, mstatus_in, mtvec_in);
          2'b10: model_push_trap(trap_pc, trap_cause, mstatus_in, mtvec_in);
          2'b01: begin
            exp_q.push_back({1'b0, 12'h300, model_mret_status(mstatus_in)});
            exp_q.push_back({1'b1, 12'h000, mepc_in});
          end
          default: ;
        endcase
      end else if (irq_timer && mstatus_in[3]) begin
        model_push_trap(irq_pc, 32'h80000007, mstatus_in, mtvec_in);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
